// File: rtl/hex_message_scroller.sv
`default_nettype none
// ============================================================================
// Module   : hex_message_scroller
// Brief    : Scrolls a four-nibble window circularly through a 16-nibble
//            message buffer at a programmable rate for a 7-segment driver.
// Revision : 1.0 - initial release
// ============================================================================
module hex_message_scroller #(
    parameter int MSG_LEN = 16,
    parameter int RATE_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [3:0]        wr_data,
    output logic              wr_ready,
    input  logic              start,
    input  logic              stop,
    input  logic [RATE_W-1:0] rate,
    output logic [3:0]        hex3,
    output logic [3:0]        hex2,
    output logic [3:0]        hex1,
    output logic [3:0]        hex0,
    output logic              busy,
    output logic              wrap
);

    localparam logic [RATE_W-1:0] c_ONE = {{(RATE_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_buf [MSG_LEN];
    logic [3:0]        r_pos;
    logic [RATE_W-1:0] r_cnt;
    logic [RATE_W-1:0] r_rate_q;
    logic [3:0]        r_hex3, r_hex2, r_hex1, r_hex0;
    logic              r_wrap_pend;
    logic              r_wrap;
    logic              w_accept_start;
    logic              w_halt;
    logic              w_step;
    logic              w_buf_we;
    logic [3:0]        w_idx1, w_idx2, w_idx3;

    assign w_idx1 = r_pos + 4'd1;
    assign w_idx2 = r_pos + 4'd2;
    assign w_idx3 = r_pos + 4'd3;

    always_comb begin
        w_state_next   = r_state;
        w_accept_start = 1'b0;
        w_halt         = 1'b0;
        w_step         = 1'b0;
        w_buf_we       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_buf_we = wr_en;
                // stop wins over a simultaneous start
                if (start && !stop) begin
                    w_accept_start = 1'b1;
                    w_state_next   = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_halt       = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_cnt == r_rate_q - c_ONE) begin
                    w_step = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            for (int i = 0; i < MSG_LEN; i++) begin
                r_buf[i] <= 4'd0;
            end
            r_pos       <= 4'd0;
            r_cnt       <= '0;
            r_rate_q    <= c_ONE;
            r_hex3      <= 4'd0;
            r_hex2      <= 4'd0;
            r_hex1      <= 4'd0;
            r_hex0      <= 4'd0;
            r_wrap_pend <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_buf_we) begin
                r_buf[wr_addr] <= wr_data;
            end
            if (w_accept_start) begin
                r_rate_q <= (rate == '0) ? c_ONE : rate;
                r_cnt    <= '0;
            end else if (w_halt) begin
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                if (w_step) begin
                    r_cnt <= '0;
                    r_pos <= w_idx1;
                end else begin
                    r_cnt <= r_cnt + c_ONE;
                end
            end
            // wrap is delayed one cycle so it lines up with the window showing pos 0
            r_wrap_pend <= w_step && (r_pos == 4'hF);
            r_wrap      <= r_wrap_pend;
            r_hex3      <= r_buf[r_pos];
            r_hex2      <= r_buf[w_idx1];
            r_hex1      <= r_buf[w_idx2];
            r_hex0      <= r_buf[w_idx3];
        end
    end

    assign wr_ready = (r_state == S_IDLE);
    assign busy     = (r_state == S_RUN);
    assign wrap     = r_wrap;
    assign hex3     = r_hex3;
    assign hex2     = r_hex2;
    assign hex1     = r_hex1;
    assign hex0     = r_hex0;

endmodule
`default_nettype wire

// File: tb/tb_hex_message_scroller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_message_scroller
// Brief    : Directed self-checking bench for hex_message_scroller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_message_scroller;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_data;
    logic        wr_ready;
    logic        start;
    logic        stop;
    logic [23:0] rate;
    logic [3:0]  hex3, hex2, hex1, hex0;
    logic        busy;
    logic        wrap;
    logic [15:0] win;

    int checks = 0;
    int errors = 0;

    assign win = {hex3, hex2, hex1, hex0};

    always #5 clk = ~clk;

    hex_message_scroller #(.MSG_LEN(16), .RATE_W(24)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .start    (start),
        .stop     (stop),
        .rate     (rate),
        .hex3     (hex3),
        .hex2     (hex2),
        .hex1     (hex1),
        .hex0     (hex0),
        .busy     (busy),
        .wrap     (wrap)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_en = 1'b0; wr_addr = 4'd0; wr_data = 4'd0;
        start = 1'b0; stop = 1'b0; rate = 24'd0;
    endtask

    task automatic randomize_inputs();
        wr_en   = 1'($urandom);
        wr_addr = 4'($urandom);
        wr_data = 4'($urandom);
        start   = 1'($urandom);
        stop    = 1'($urandom);
        rate    = 24'($urandom);
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        randomize_inputs();
        #1;
        checks++;
        if (win !== 16'h0000 || busy !== 1'b0 || wrap !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_initial: hex=%h busy=%b wrap=%b wr_ready=%b, want 0000/0/0/1", win, busy, wrap, wr_ready);
        end
        tick(); tick();
        clear_inputs();
        reset = 1'b1;
        tick();
        // load something and get running, then reset between clock edges
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 4'd7;
        tick();
        wr_en = 1'b0; start = 1'b1; rate = 24'd1;
        tick();
        start = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_prerun_busy: busy=%b, want 1", busy);
        end
        reset = 1'b0;
        randomize_inputs();
        #2;
        checks++;
        if (win !== 16'h0000 || busy !== 1'b0 || wrap !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: hex=%h busy=%b wrap=%b wr_ready=%b, want 0000/0/0/1", win, busy, wrap, wr_ready);
        end
        tick();
        clear_inputs();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load_scroll();
        logic [3:0]  p;
        logic [15:0] exp;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 4'(i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        checks++;
        if (win !== 16'h0123) begin
            errors++;
            $display("FAIL load_window: hex=%h, want 0123", win);
        end
        rate = 24'd3; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_busy: busy=%b wr_ready=%b, want 1/0", busy, wr_ready);
        end
        for (int n = 1; n <= 50; n++) begin
            tick();
            p   = 4'((n - 1) / 3);
            exp = {p, p + 4'd1, p + 4'd2, p + 4'd3};
            checks++;
            if (win !== exp || wrap !== (n == 49)) begin
                errors++;
                $display("FAIL scroll_rate3 n=%0d: hex=%h wrap=%b, want %h/%b", n, win, wrap, exp, (n == 49));
            end
        end
    endtask

    task automatic test_write_lockout();
        bit found = 0;
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 4'hA;
        tick();
        wr_en = 1'b0;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL lockout_wr_ready: wr_ready=%b, want 0", wr_ready);
        end
        for (int k = 0; k < 100 && !found; k++) begin
            tick();
            if (win[15:4] === 12'h234) found = 1;
        end
        checks++;
        if (!found || win !== 16'h2345) begin
            errors++;
            $display("FAIL lockout_buf5: hex=%h found=%b, want 2345", win, found);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || wr_ready !== 1'b1 || win !== 16'h2345) begin
            errors++;
            $display("FAIL lockout_stop: busy=%b wr_ready=%b hex=%h, want 0/1/2345", busy, wr_ready, win);
        end
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 4'hA;
        tick();
        wr_en = 1'b0;
        checks++;
        if (win !== 16'h2345) begin
            errors++;
            $display("FAIL idle_write_latency: hex=%h, want 2345", win);
        end
        tick();
        checks++;
        if (win !== 16'h234A) begin
            errors++;
            $display("FAIL idle_write_visible: hex=%h, want 234A", win);
        end
    endtask

    task automatic test_stop_resume();
        bit          found = 0;
        logic [15:0] exp_tab [5] = '{16'h6789, 16'h6789, 16'h789A, 16'h89AB, 16'h9ABC};
        rate = 24'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            tick();
            if (win === 16'h6789) found = 1;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (!found || busy !== 1'b0 || win !== 16'h6789) begin
            errors++;
            $display("FAIL stop_freeze: found=%b busy=%b hex=%h, want 1/0/6789", found, busy, win);
        end
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b0 || win !== 16'h6789) begin
            errors++;
            $display("FAIL stop_hold: busy=%b hex=%h, want 0/6789", busy, win);
        end
        rate = 24'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 5; n++) begin
            if (n > 0) tick();
            checks++;
            if (win !== exp_tab[n] || busy !== 1'b1) begin
                errors++;
                $display("FAIL resume_rate1 n=%0d: hex=%h busy=%b, want %h/1", n, win, busy, exp_tab[n]);
            end
        end
    endtask

    task automatic test_start_stop_idle();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || win !== 16'hABCD) begin
            errors++;
            $display("FAIL stop_no_step: busy=%b hex=%h, want 0/ABCD", busy, win);
        end
        start = 1'b1; stop = 1'b1; rate = 24'd1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_stop_same: busy=%b wr_ready=%b, want 0/1", busy, wr_ready);
        end
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b0 || win !== 16'hABCD) begin
            errors++;
            $display("FAIL start_stop_pos: busy=%b hex=%h, want 0/ABCD", busy, win);
        end
    endtask

    task automatic test_rate_zero_reset();
        logic [15:0] exp_tab [4] = '{16'hABCD, 16'hABCD, 16'hBCDE, 16'hCDEF};
        rate = 24'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (n > 0) tick();
            checks++;
            if (win !== exp_tab[n] || busy !== 1'b1) begin
                errors++;
                $display("FAIL rate0 n=%0d: hex=%h busy=%b, want %h/1", n, win, busy, exp_tab[n]);
            end
        end
        reset = 1'b0;
        randomize_inputs();
        #2;
        checks++;
        if (win !== 16'h0000 || busy !== 1'b0 || wrap !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_midrun: hex=%h busy=%b wrap=%b wr_ready=%b, want 0000/0/0/1", win, busy, wrap, wr_ready);
        end
        tick();
        clear_inputs();
        reset = 1'b1;
        tick();
        rate = 24'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 18; n++) begin
            tick();
            checks++;
            if (win !== 16'h0000) begin
                errors++;
                $display("FAIL buf_cleared n=%0d: hex=%h, want 0000", n, win);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_load_scroll();
        test_write_lockout();
        test_stop_resume();
        test_start_stop_idle();
        test_rate_zero_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex_message_scroller.md
Name: hex_message_scroller

Overview:
- Sequencer for the four-digit seven-segment driver.
- Holds a 16-nibble message buffer and presents a four-nibble window on hex3..hex0.
- Advances the window through the buffer at a programmable tick rate, wrapping circularly.
- Sits between the host/control logic and the digit driver's hex3..hex0 inputs, on the same clk domain.

Parameters:
- MSG_LEN, 16, message buffer depth in nibbles; fixed power of two (address width 4).
- RATE_W, 24, width of the rate input and the internal prescaler counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  buffer write strobe; honoured only when wr_ready=1.
- wr_addr  input  4  buffer write address.
- wr_data  input  4  nibble to write.
- wr_ready  output  1  high when the buffer accepts writes (IDLE only).
- start  input  1  single-cycle request to begin scrolling.
- stop  input  1  single-cycle request to halt scrolling.
- rate  input  RATE_W  clocks per scroll step; sampled on accepted start.
- hex3  output  4  leftmost digit = buf[pos].
- hex2  output  4  buf[(pos+1) mod 16].
- hex1  output  4  buf[(pos+2) mod 16].
- hex0  output  4  rightmost digit = buf[(pos+3) mod 16].
- busy  output  1  high in RUN.
- wrap  output  1  one-cycle pulse when pos steps 15->0.

Behaviour:
Reset (reset=0, async), all registers cleared as follows:
- buf[all]=0, pos=0, prescaler cnt=0, rate_q=1.
- state=IDLE.
- hex3..hex0=0, busy=0, wrap=0, wr_ready=1.
- Reset asserted mid-RUN aborts immediately to these values; buffer contents are lost.

States:
- IDLE: wr_ready=1, busy=0.
  - wr_en writes buf[wr_addr]<=wr_data on that edge.
  - start (with stop=0) -> RUN.
  - On that transition: rate_q<=(rate==0 ? 1 : rate), cnt<=0.
  - pos is not reset by start; scrolling resumes from the frozen position.
- RUN: wr_ready=0, busy=1.
  - wr_en is ignored and the buffer is unchanged.
  - Each cycle: if cnt==rate_q-1, then cnt<=0 and pos<=pos+1 mod 16 (a step); else cnt<=cnt+1.
  - stop -> IDLE on the next edge; pos frozen, cnt<=0; no step occurs on the stop cycle.
  - start while in RUN is ignored; rate changes take effect only at the next accepted start.

Simultaneous events:
- start and stop asserted in the same IDLE cycle: stop wins and the block stays in IDLE.
- stop while in IDLE: no effect.

Output timing:
- hex3..hex0 are registered, recomputed every cycle from buf and pos.
- They reflect a pos or buffer change on the clock edge following that change (1-cycle latency).
- In IDLE they track buffer writes with the same 1-cycle latency.
- Window indices are computed mod 16 (natural 4-bit wrap).

wrap:
- Registered; asserted for exactly one cycle, coincident with hex outputs first showing pos=0 after a 15->0 step.
- Not asserted on reset or on start.

Step period:
- Steps occur every rate_q clocks.
- First step after start occurs rate_q clocks after the start edge.
- rate=1 or rate=0: step every clock.

No combinational path from any input to any output.

Test Plan:
1. Reset: drive reset=0 mid-simulation with random inputs -> hex3..hex0=0, busy=0, wrap=0, wr_ready=1, asynchronously without waiting for a clk edge.
2. Load and scroll: write buf[i]=i for i=0..15, start with rate=3 -> hex3..0 shows 0,1,2,3, then 1,2,3,4 three clocks later.
   - Window advances every 3 clocks.
   - After 16 steps it shows 0,1,2,3 again, with wrap high for exactly one cycle as the window goes F,0,1,2 -> 0,1,2,3.
3. Write lockout: during RUN pulse wr_en with wr_addr=5, wr_data=A -> buf[5] unchanged and wr_ready=0.
   - After stop, the same write is accepted and appears on the appropriate digit one cycle later.
4. Stop/resume: stop while the window shows 6,7,8,9 -> outputs freeze at 6,7,8,9 and busy=0.
   - Start with rate=1 -> window steps every clock starting from 7,8,9,A.
5. Simultaneous start+stop in IDLE -> state stays IDLE, busy stays 0, and pos is unchanged.
6. rate=0 at start -> behaves as rate=1 (step every clock).
   - Then assert reset mid-RUN -> all outputs return to reset values and buffer reads back all zeros.
